// File: rtl/mul_seq_nbits_pkg.sv
// Shared definitions for the sequential multiplier family.
// State encodings are fixed so future mul/div sequencers decode them identically.
package mul_seq_nbits_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_CALC = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam int MUL_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the ripple adders of the multiplier datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add mplier into acc, then shift {acc,mcand} right by one.
module mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] mcand_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   sum;

  assign addend   = mcand_i[0] ? mplier_i : '0;
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      full_adder u_fa (
        .a_i (acc_i[gi]),
        .b_i (addend[gi]),
        .c_i (carry[gi]),
        .s_o (sum[gi]),
        .c_o (carry[gi+1])
      );
    end
  endgenerate

  // acc enters each step below 2^WIDTH, so the top bit only ever absorbs the carry.
  assign sum[WIDTH] = acc_i[WIDTH] ^ carry[WIDTH];

  assign acc_o   = {1'b0, sum[WIDTH:1]};
  assign mcand_o = {sum[0], mcand_i[WIDTH-1:1]};

endmodule

// File: rtl/mul_seq_nbits.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock,
// with per-operation signed/unsigned mode and valid/ready handshakes on both sides.
module mul_seq_nbits
  import mul_seq_nbits_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  ms_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH:0]       acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   out_q;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;

  logic [WIDTH:0]       acc_d;
  logic [WIDTH-1:0]     mcand_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic [2*WIDTH-1:0]   out_d;
  logic                 x_neg;
  logic                 y_neg;
  logic [WIDTH-1:0]     x_mag;
  logic [WIDTH-1:0]     y_mag;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign x_neg = is_signed & x[WIDTH-1];
  assign y_neg = is_signed & y[WIDTH-1];
  assign x_mag = x_neg ? -x : x;
  assign y_mag = y_neg ? -y : y;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d)
  );

  assign prod_d = {acc_d[WIDTH-1:0], mcand_d};
  assign out_d  = neg_q ? -prod_d : prod_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MS_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (in_valid && in_ready_q) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            mcand_q    <= x_mag;
            mplier_q   <= y_mag;
            neg_q      <= x_neg ^ y_neg;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= MS_CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        MS_CALC: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            out_q       <= out_d;
            out_valid_q <= 1'b1;
            state_q     <= MS_DONE;
          end
        end
        MS_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= MS_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= MS_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_nbits.sv
// Scoreboarded bench for the 4-bit configuration: directed vectors, latency, backpressure,
// mid-operation reset, and an exhaustive sweep in both modes.
module tb_mul_seq_nbits;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  mul_seq_nbits #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge whenever both are high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [2*W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL product: unexpected output %0h with empty scoreboard", out);
      end else begin
        e = exp_q.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL product: got %0h expected %0h", out, e);
        end else begin
          $display("product %0h ok", out);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] e);
    int t;
    t = 0;
    in_valid  = 1'b1;
    is_signed = s;
    x         = a;
    y         = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
    $display("issue s=%0b x=%0h y=%0h expect %0h", s, a, b, e);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      t++;
      if (t > 50) begin
        chk("out_valid_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] e;
  } vec_t;

  vec_t vecs[$] = '{
    '{1'b0, 4'hF, 4'hF, 8'hE1},
    '{1'b1, 4'h8, 4'h8, 8'h40},
    '{1'b1, 4'hD, 4'h5, 8'hF1},
    '{1'b1, 4'h0, 4'hF, 8'h00},
    '{1'b1, 4'h7, 4'h8, 8'hC8},
    '{1'b0, 4'h1, 4'hF, 8'h0F},
    '{1'b1, 4'hF, 4'hF, 8'h01},
    '{1'b0, 4'h8, 4'h8, 8'h40},
    '{1'b1, 4'h7, 4'h7, 8'h31},
    '{1'b1, 4'h1, 4'h8, 8'hF8},
    '{1'b0, 4'h0, 4'h0, 8'h00}
  };

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // Latency: 15*15 unsigned, out_valid on the 4th edge after accept.
    issue(1'b0, 4'hF, 4'hF, 8'hE1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat_out_valid_low", 32'(out_valid), 32'h0);
      chk("lat_in_ready_low", 32'(in_ready), 32'h0);
    end
    @(negedge clk);
    chk("lat_out_valid_high", 32'(out_valid), 32'h1);
    @(posedge clk); #1;

    foreach (vecs[i]) issue(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].e);

    // Backpressure: product and flags hold while the consumer stalls.
    wait_out_valid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(1'b1, 4'hD, 4'h5, 8'hF1);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out", 32'(out), 32'hF1);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    chk("bp_release_out_valid", 32'(out_valid), 32'h0);
    chk("bp_out_held", 32'(out), 32'hF1);
    chk("bp_release_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // Reset two cycles into CALC discards the operation.
    issue(1'b0, 4'h5, 4'h5, 8'h19);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    issue(1'b0, 4'h7, 4'h3, 8'h15);

    // Exhaustive sweep, both modes, back to back.
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          logic [W-1:0] av;
          logic [W-1:0] bv;
          int prod;
          av = W'(a);
          bv = W'(b);
          prod = (m == 1) ? int'($signed(av)) * int'($signed(bv)) : a * b;
          issue(m[0], av, bv, (2*W)'(prod));
        end
      end
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
